// File: rtl/cariomart_pkg.sv
// Shared constants and state encodings for the controller link receiver.
package cariomart_pkg;

  localparam int unsigned FRAME_LEN  = 5;
  localparam int unsigned OFF_SYNC   = 0;
  localparam int unsigned OFF_STEER  = 1;
  localparam int unsigned OFF_THR    = 2;
  localparam int unsigned OFF_BTN    = 3;
  localparam int unsigned OFF_CHK    = 4;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {HUNT, STEER, THR, BTN, CHK} parser_state_e;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  // Rounded clock divider producing one tick per oversample slot.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    return 8'(a + b + c);
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchroniser, oversample tick divider and bit FSM.
module uart_rx_8n1
  import cariomart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 40000000,
  parameter int unsigned BAUD       = 57600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int unsigned DIV  = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OW   = $clog2(OVERSAMPLE);
  localparam int unsigned HALF = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST = OVERSAMPLE - 1;

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [DW-1:0] div_q, div_d;
  logic [OW-1:0] os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rxs, fall, tick;

  assign rxs  = sync_q[1];
  assign fall = prev_q & ~rxs;
  assign tick = (div_q == DW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rxd};
      prev_q <= rxs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : DW'(div_q + 1'b1);
    os_d    = os_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        div_d = '0;
        os_d  = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: if (tick) begin
        os_d = OW'(os_q + 1'b1);
        // Mid start bit: a high line here means the edge was a glitch.
        if (os_q == OW'(HALF)) begin
          os_d    = '0;
          bit_d   = '0;
          state_d = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (tick) begin
        os_d = OW'(os_q + 1'b1);
        if (os_q == OW'(LAST)) begin
          os_d  = '0;
          sh_d  = {rxs, sh_q[7:1]};
          bit_d = 3'(bit_q + 1'b1);
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: if (tick) begin
        os_d = OW'(os_q + 1'b1);
        if (os_q == OW'(LAST)) begin
          os_d = '0;
          if (rxs) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        div_d = '0;
        if (rxs) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte     = sh_q;
  assign byte_valid  = valid_q;
  assign framing_err = ferr_q;

endmodule

// File: rtl/controller_frame_rx.sv
// Controller link receiver: frame parser, shadow/output registers, timeout, IRQ and counter.
module controller_frame_rx
  import cariomart_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 40000000,
  parameter int unsigned BAUD           = 57600,
  parameter int unsigned OVERSAMPLE     = 16,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 80000
) (
  input  logic        FAB_CLK,
  input  logic        FAB_RESET,
  input  logic        RXD,
  input  logic        IRQ_CLR,
  output logic [7:0]  FRAME_STEER,
  output logic [7:0]  FRAME_THROTTLE,
  output logic [7:0]  FRAME_BUTTONS,
  output logic        FRAME_VALID,
  output logic        FRAME_IRQ,
  output logic        ERR_CHECKSUM,
  output logic        ERR_FRAMING,
  output logic [15:0] FRAME_COUNT
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_rx (
    .clk        (FAB_CLK),
    .rst        (FAB_RESET),
    .rxd        (RXD),
    .rx_byte    (rx_byte),
    .byte_valid (rx_valid),
    .framing_err(rx_ferr)
  );

  parser_state_e state_q, state_d;
  logic [7:0]    steer_sh_q, steer_sh_d, thr_sh_q, thr_sh_d, btn_sh_q, btn_sh_d;
  logic [7:0]    steer_q, steer_d, thr_q, thr_d, btn_q, btn_d;
  logic          valid_q, valid_d, irq_q, irq_d, ecks_q, ecks_d, efrm_q, efrm_d;
  logic [15:0]   count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          load_c, cks_bad_c;

  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) state_q <= HUNT;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    steer_sh_d = steer_sh_q;
    thr_sh_d   = thr_sh_q;
    btn_sh_d   = btn_sh_q;
    load_c     = 1'b0;
    cks_bad_c  = 1'b0;
    tmo_d      = (state_q == HUNT || rx_valid) ? '0 : TW'(tmo_q + 1'b1);
    if (rx_valid) begin
      unique case (state_q)
        HUNT:  if (rx_byte == SYNC_BYTE) state_d = STEER;
        STEER: begin steer_sh_d = rx_byte; state_d = THR; end
        THR:   begin thr_sh_d   = rx_byte; state_d = BTN; end
        BTN:   begin btn_sh_d   = rx_byte; state_d = CHK; end
        CHK: begin
          if (rx_byte == frame_sum(steer_sh_q, thr_sh_q, btn_sh_q)) load_c = 1'b1;
          else                                                     cks_bad_c = 1'b1;
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT && (rx_ferr || tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
      state_d = HUNT;
    end

    // All output fields update together on a good frame; set beats clear.
    steer_d = load_c ? steer_sh_q : steer_q;
    thr_d   = load_c ? thr_sh_q   : thr_q;
    btn_d   = load_c ? btn_sh_q   : btn_q;
    count_d = load_c ? 16'(count_q + 16'd1) : count_q;
    valid_d = load_c;
    irq_d   = load_c | (irq_q & ~IRQ_CLR);
    ecks_d  = cks_bad_c;
    efrm_d  = rx_ferr;
  end

  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      steer_sh_q <= '0;
      thr_sh_q   <= '0;
      btn_sh_q   <= '0;
      steer_q    <= '0;
      thr_q      <= '0;
      btn_q      <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      irq_q      <= 1'b0;
      ecks_q     <= 1'b0;
      efrm_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      steer_sh_q <= steer_sh_d;
      thr_sh_q   <= thr_sh_d;
      btn_sh_q   <= btn_sh_d;
      steer_q    <= steer_d;
      thr_q      <= thr_d;
      btn_q      <= btn_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      irq_q      <= irq_d;
      ecks_q     <= ecks_d;
      efrm_q     <= efrm_d;
      tmo_q      <= tmo_d;
    end
  end

  assign FRAME_STEER    = steer_q;
  assign FRAME_THROTTLE = thr_q;
  assign FRAME_BUTTONS  = btn_q;
  assign FRAME_VALID    = valid_q;
  assign FRAME_IRQ      = irq_q;
  assign ERR_CHECKSUM   = ecks_q;
  assign ERR_FRAMING    = efrm_q;
  assign FRAME_COUNT    = count_q;

endmodule

// File: tb/tb_controller_frame_rx.sv
// Bench for controller_frame_rx: table-driven frames, scoreboard of expected pulses, corner sequences.
module tb_controller_frame_rx;

  localparam int unsigned CLK_HZ  = 1843200;
  localparam int unsigned BAUD    = 57600;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned BIT     = CLK_HZ / BAUD;
  localparam int EV_VALID = 0;
  localparam int EV_CKS   = 1;
  localparam int EV_FRM   = 2;

  logic        FAB_CLK = 1'b0;
  logic        FAB_RESET, RXD, IRQ_CLR;
  logic [7:0]  FRAME_STEER, FRAME_THROTTLE, FRAME_BUTTONS;
  logic        FRAME_VALID, FRAME_IRQ, ERR_CHECKSUM, ERR_FRAMING;
  logic [15:0] FRAME_COUNT;

  controller_frame_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET), .RXD(RXD), .IRQ_CLR(IRQ_CLR),
    .FRAME_STEER(FRAME_STEER), .FRAME_THROTTLE(FRAME_THROTTLE), .FRAME_BUTTONS(FRAME_BUTTONS),
    .FRAME_VALID(FRAME_VALID), .FRAME_IRQ(FRAME_IRQ), .ERR_CHECKSUM(ERR_CHECKSUM),
    .ERR_FRAMING(ERR_FRAMING), .FRAME_COUNT(FRAME_COUNT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    int         kind;
    logic [7:0] s, t, k;
    logic [15:0] c;
  } ev_t;

  typedef struct {
    logic [47:0] bytes;
    int          n;
    int          bad;
    int          ev;
    logic [7:0]  s, t, k;
  } vec_t;

  ev_t  sb_q[$];
  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;
  logic [7:0]  exp_s = '0, exp_t = '0, exp_k = '0;
  logic [15:0] exp_count = '0;
  logic        exp_irq = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] s, input logic [7:0] t,
                      input logic [7:0] k, input logic [15:0] c);
    ev_t e;
    e.kind = kind; e.s = s; e.t = t; e.k = k; e.c = c;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int unsigned cycles);
    repeat (cycles) @(negedge FAB_CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    RXD = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      idle(BIT);
    end
    RXD = ~bad_stop;
    idle(BIT);
    RXD = 1'b1;
    if (bad_stop) idle(BIT);
  endtask

  task automatic send_bytes(input logic [47:0] bytes, input int n, input int bad_idx);
    for (int i = 0; i < n; i++) send_byte(bytes[47-8*i -: 8], i == bad_idx);
  endtask

  task automatic expect_good(input logic [7:0] s, input logic [7:0] t, input logic [7:0] k);
    exp_count = 16'(exp_count + 16'd1);
    exp_s = s; exp_t = t; exp_k = k; exp_irq = 1'b1;
    push(EV_VALID, s, t, k, exp_count);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_steer"}, 32'(FRAME_STEER), 32'(exp_s));
    check({tag, "_thr"},   32'(FRAME_THROTTLE), 32'(exp_t));
    check({tag, "_btn"},   32'(FRAME_BUTTONS), 32'(exp_k));
    check({tag, "_irq"},   32'(FRAME_IRQ), 32'(exp_irq));
    check({tag, "_count"}, 32'(FRAME_COUNT), 32'(exp_count));
  endtask

  // Every pulse from the DUT must match the oldest pending expectation.
  always @(negedge FAB_CLK) begin
    if (FRAME_VALID || ERR_CHECKSUM || ERR_FRAMING) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, FRAME_VALID, ERR_CHECKSUM, ERR_FRAMING}, 32'd0);
      end else begin
        ev_t e;
        int  kind;
        e = sb_q.pop_front();
        kind = FRAME_VALID ? EV_VALID : (ERR_CHECKSUM ? EV_CKS : EV_FRM);
        check("pulse_kind", 32'(kind), 32'(e.kind));
        if (e.kind == EV_VALID) begin
          check("ev_steer", 32'(FRAME_STEER), 32'(e.s));
          check("ev_thr",   32'(FRAME_THROTTLE), 32'(e.t));
          check("ev_btn",   32'(FRAME_BUTTONS), 32'(e.k));
          check("ev_count", 32'(FRAME_COUNT), 32'(e.c));
          check("ev_irq",   32'(FRAME_IRQ), 32'd1);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    vecs[0] = '{bytes: 48'hA5_10_80_01_91_00, n: 5, bad: -1, ev: EV_VALID, s: 8'h10, t: 8'h80, k: 8'h01};
    vecs[1] = '{bytes: 48'hA5_10_80_01_92_00, n: 5, bad: -1, ev: EV_CKS,   s: 8'h00, t: 8'h00, k: 8'h00};
    vecs[2] = '{bytes: 48'h00_A5_A5_A5_A5_A5, n: 6, bad: -1, ev: EV_CKS,   s: 8'h00, t: 8'h00, k: 8'h00};
    vecs[3] = '{bytes: 48'hA5_10_80_00_00_00, n: 3, bad: 2,  ev: EV_FRM,   s: 8'h00, t: 8'h00, k: 8'h00};
    vecs[4] = '{bytes: 48'hA5_01_02_03_06_00, n: 5, bad: -1, ev: EV_VALID, s: 8'h01, t: 8'h02, k: 8'h03};
    vecs[5] = '{bytes: 48'hA5_FF_A5_00_A4_00, n: 5, bad: -1, ev: EV_VALID, s: 8'hFF, t: 8'hA5, k: 8'h00};
    vecs[6] = '{bytes: 48'hA5_7F_01_80_00_00, n: 5, bad: -1, ev: EV_VALID, s: 8'h7F, t: 8'h01, k: 8'h80};

    FAB_RESET = 1'b1; RXD = 1'b1; IRQ_CLR = 1'b0;
    idle(5);
    check_outputs("reset");
    FAB_RESET = 1'b0;
    idle(2 * BIT);
    check_outputs("post_reset");

    foreach (vecs[i]) begin
      if (vecs[i].ev == EV_VALID) expect_good(vecs[i].s, vecs[i].t, vecs[i].k);
      else push(vecs[i].ev, 8'h00, 8'h00, 8'h00, 16'h0000);
      send_bytes(vecs[i].bytes, vecs[i].n, vecs[i].bad);
      idle(3 * BIT);
      check_outputs($sformatf("vec%0d", i));
    end

    // Fragment followed by a gap longer than the timeout must be dropped silently.
    send_bytes(48'hA5_10_00_00_00_00, 2, -1);
    idle(TIMEOUT + 500);
    expect_good(8'h11, 8'h22, 8'h33);
    send_bytes(48'hA5_11_22_33_66_00, 5, -1);
    idle(3 * BIT);
    check_outputs("timeout");

    // IRQ_CLR coinciding with the frame load, then held one more cycle.
    expect_good(8'h05, 8'h06, 8'h07);
    send_bytes(48'hA5_05_06_07_00_00, 4, -1);
    fork
      send_byte(8'h12, 1'b0);
      begin
        seen = 1'b0;
        for (int c = 0; c < 12 * BIT && !seen; c++) begin
          @(negedge FAB_CLK);
          if (dut.rx_valid) seen = 1'b1;
        end
        check("chk_byte_seen", 32'(seen), 32'd1);
        IRQ_CLR = 1'b1;
        @(negedge FAB_CLK);
        check("irq_set_wins", 32'(FRAME_IRQ), 32'd1);
        @(negedge FAB_CLK);
        IRQ_CLR = 1'b0;
        check("irq_cleared", 32'(FRAME_IRQ), 32'd0);
      end
    join
    exp_irq = 1'b0;
    idle(3 * BIT);
    check_outputs("irq_clr");

    // Counter wrap from FFFF.
    force dut.count_q = 16'hFFFF;
    idle(2);
    release dut.count_q;
    idle(2);
    exp_count = 16'hFFFF;
    expect_good(8'h01, 8'h01, 8'h01);
    send_bytes(48'hA5_01_01_01_03_00, 5, -1);
    idle(3 * BIT);
    check_outputs("wrap");

    // Reset in the middle of the BTN byte.
    send_bytes(48'hA5_20_30_00_00_00, 3, -1);
    RXD = 1'b0; idle(BIT);
    RXD = 1'b1; idle(BIT);
    RXD = 1'b0; idle(BIT / 2);
    FAB_RESET = 1'b1;
    RXD = 1'b1;
    exp_s = '0; exp_t = '0; exp_k = '0; exp_count = '0; exp_irq = 1'b0;
    idle(4);
    check_outputs("mid_reset");
    FAB_RESET = 1'b0;
    idle(3 * BIT);
    check_outputs("after_reset");
    expect_good(8'h20, 8'h30, 8'h40);
    send_bytes(48'hA5_20_30_40_90_00, 5, -1);
    idle(3 * BIT);
    check_outputs("post_reset_frame");

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
